// File: rtl/traffic_pkg.sv
// Shared types for the junction controller: phase encoding, the 3-bit {Red,Yellow,Green}
// light codes, and the decode from phase to lamp outputs.
package traffic_pkg;

  typedef enum logic [2:0] {
    MAIN_G = 3'd0,
    MAIN_Y = 3'd1,
    AR1    = 3'd2,
    SIDE_G = 3'd3,
    SIDE_Y = 3'd4,
    PED    = 3'd5,
    AR2    = 3'd6
  } state_t;

  localparam logic [2:0] RED    = 3'b100;
  localparam logic [2:0] YELLOW = 3'b010;
  localparam logic [2:0] GREEN  = 3'b001;
  localparam logic [2:0] OFF    = 3'b000;

  typedef struct packed {
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic       walk;
  } lamps_t;

  function automatic lamps_t decode_lamps(input state_t s);
    lamps_t l;
    l = '{main_light: RED, side_light: RED, walk: 1'b0};
    unique case (s)
      MAIN_G:  l.main_light = GREEN;
      MAIN_Y:  l.main_light = YELLOW;
      SIDE_G:  l.side_light = GREEN;
      SIDE_Y:  l.side_light = YELLOW;
      PED:     l.walk       = 1'b1;
      default: l.walk       = 1'b0;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Cycle counter for the current phase: cleared on a phase change, optionally held
// (saturated) by the controller once it reaches the value of interest.
module phase_timer #(
  parameter int TW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          hold,
  output logic [TW-1:0] count
);

  // NOTE: sequential state is always written with non-blocking assignments so every
  // register samples the pre-edge values of its inputs.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      count <= '0;
    end else if (!hold) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/traffic_junction_ctrl.sv
// Junction sequencer: main road rests on green; side-road and pedestrian demand are
// served in turn, each bracketed by yellow and all-red clearance.
module traffic_junction_ctrl
  import traffic_pkg::*;
#(
  parameter int MAIN_MIN   = 8,
  parameter int SIDE_GREEN = 6,
  parameter int YELLOW     = 3,
  parameter int ALL_RED    = 2,
  parameter int PED_WALK   = 5,
  parameter int TW         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       side_req,
  input  logic       ped_req,
  output logic [2:0] main_light,
  output logic [2:0] side_light,
  output logic       walk,
  output logic [2:0] phase
);

  localparam logic [TW-1:0] MAIN_LAST   = TW'(MAIN_MIN - 1);
  localparam logic [TW-1:0] SIDE_LAST   = TW'(SIDE_GREEN - 1);
  localparam logic [TW-1:0] YELLOW_LAST = TW'(YELLOW - 1);
  localparam logic [TW-1:0] AR_LAST     = TW'(ALL_RED - 1);
  localparam logic [TW-1:0] WALK_LAST   = TW'(PED_WALK - 1);

  state_t        state;
  state_t        state_next;
  logic [TW-1:0] timer;
  logic          ped_pending;
  logic          last_ped;
  logic          changing;
  lamps_t        lamps_next;

  assign changing   = (state_next != state);
  assign lamps_next = decode_lamps(state_next);
  assign phase      = state;

  phase_timer #(.TW(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (changing),
    .hold  ((state == MAIN_G) && (timer == MAIN_LAST)),
    .count (timer)
  );

  // NOTE: state_next is defaulted before the case so every path assigns it and no
  // latch can be inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      MAIN_G: if (timer == MAIN_LAST && (side_req || ped_pending)) state_next = MAIN_Y;
      MAIN_Y: if (timer == YELLOW_LAST) state_next = AR1;
      AR1: begin
        if (timer == AR_LAST) begin
          // Alternate when both are waiting; a withdrawn side request falls through to AR2.
          if (side_req && ped_pending) state_next = last_ped ? SIDE_G : PED;
          else if (side_req)           state_next = SIDE_G;
          else if (ped_pending)        state_next = PED;
          else                         state_next = AR2;
        end
      end
      SIDE_G: if (timer == SIDE_LAST)   state_next = SIDE_Y;
      SIDE_Y: if (timer == YELLOW_LAST) state_next = AR2;
      PED:    if (timer == WALK_LAST)   state_next = AR2;
      AR2:    if (timer == AR_LAST)     state_next = MAIN_G;
      default: state_next = MAIN_G;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= MAIN_G;
      ped_pending <= 1'b0;
      last_ped    <= 1'b1;
      main_light  <= GREEN;
      side_light  <= RED;
      walk        <= 1'b0;
    end else begin
      state      <= state_next;
      main_light <= lamps_next.main_light;
      side_light <= lamps_next.side_light;
      walk       <= lamps_next.walk;
      // Entering PED consumes the request, including one arriving on that same edge.
      if (changing && state_next == PED) ped_pending <= 1'b0;
      else if (ped_req)                  ped_pending <= 1'b1;
      if (changing && state_next == PED)    last_ped <= 1'b1;
      if (changing && state_next == SIDE_G) last_ped <= 1'b0;
    end
  end

endmodule
